// File: rtl/security_response_controller_pkg.sv
// Shared level/state encodings for the hazard chain and blink-period helper.
package security_response_controller_pkg;

  localparam logic [1:0] LVL_IDLE     = 2'd0;
  localparam logic [1:0] LVL_WATCH    = 2'd1;
  localparam logic [1:0] LVL_WARN     = 2'd2;
  localparam logic [1:0] LVL_LOCKDOWN = 2'd3;

  // Floor of the half period in clock cycles for a given blink frequency.
  function automatic int unsigned half_period(int unsigned clk_hz, int unsigned blink_hz);
    return clk_hz / (2 * blink_hz);
  endfunction

endpackage

// File: rtl/security_response_controller_blink_generator.sv
// Square-wave phase generator; restart forces phase high and clears the counter.
module blink_generator #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [CNT_W-1:0] half_period,
  output logic             phase
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;
  logic [CNT_W-1:0] w_last;

  assign w_last = half_period - CNT_ONE;
  assign phase  = r_phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == w_last) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/security_response_controller.sv
// Maps security level to LED/buzzer/lock: immediate escalation, held de-escalation,
// latched lockdown released by operator acknowledge.
module security_response_controller
  import security_response_controller_pkg::*;
#(
  parameter int unsigned CLOCK_RATE       = 100_000_000,
  parameter int unsigned BLINK_HZ_L1      = 1,
  parameter int unsigned BLINK_HZ_L2      = 4,
  parameter int unsigned HOLD_TIME_IN_SEC = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] security_level,
  input  logic       ack,
  output logic [1:0] current_level,
  output logic       alarm_led,
  output logic       buzzer,
  output logic       door_lock
);

  localparam int unsigned HP1         = half_period(CLOCK_RATE, BLINK_HZ_L1);
  localparam int unsigned HP2         = half_period(CLOCK_RATE, BLINK_HZ_L2);
  localparam int unsigned HP_MAX      = (HP1 > HP2) ? HP1 : HP2;
  localparam int unsigned BLINK_W     = $clog2(HP_MAX) + 1;
  localparam int unsigned HOLD_CYCLES = CLOCK_RATE * HOLD_TIME_IN_SEC - 1;
  localparam int unsigned HOLD_W      = $clog2(HOLD_CYCLES) + 1;

  localparam logic [BLINK_W-1:0] HP1_V      = BLINK_W'(HP1);
  localparam logic [BLINK_W-1:0] HP2_V      = BLINK_W'(HP2);
  localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

  logic [1:0]        r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_mute;
  logic              r_ack_q;
  logic              r_led;
  logic              r_buzzer;
  logic              r_lock;

  logic [1:0]         w_state_d;
  logic [HOLD_W-1:0]  w_hold_d;
  logic               w_mute_d;
  logic               w_ack_rise;
  logic               w_state_change;
  logic [BLINK_W-1:0] w_half_period;
  logic               w_phase;
  logic               w_led_d;
  logic               w_buzzer_d;
  logic               w_lock_d;

  assign w_ack_rise     = ack & ~r_ack_q;
  assign w_state_change = (w_state_d != r_state);
  assign w_half_period  = (r_state == LVL_WARN) ? HP2_V : HP1_V;

  always_comb begin
    w_state_d = r_state;
    w_hold_d  = '0;
    w_mute_d  = r_mute;
    if (security_level > r_state) begin
      w_state_d = security_level;
    end else if (r_state == LVL_LOCKDOWN) begin
      // Lockdown only releases on a fresh acknowledge once the threat has dropped.
      if (w_ack_rise && (security_level != LVL_LOCKDOWN)) begin
        w_state_d = security_level;
      end
    end else if (security_level < r_state) begin
      if (r_hold == HOLD_LIMIT) begin
        w_state_d = security_level;
      end else begin
        w_hold_d = r_hold + HOLD_ONE;
      end
    end

    if (w_state_d != r_state) begin
      w_mute_d = 1'b0;
    end else if ((r_state == LVL_WARN) && w_ack_rise) begin
      w_mute_d = 1'b1;
    end
  end

  always_comb begin
    w_led_d    = 1'b0;
    w_buzzer_d = 1'b0;
    w_lock_d   = 1'b0;
    case (r_state)
      LVL_WATCH: w_led_d = w_phase;
      LVL_WARN: begin
        w_led_d    = w_phase;
        w_buzzer_d = w_phase & ~r_mute;
      end
      LVL_LOCKDOWN: begin
        w_led_d    = 1'b1;
        w_buzzer_d = 1'b1;
        w_lock_d   = 1'b1;
      end
      default: ;
    endcase
  end

  blink_generator #(
    .CNT_W (BLINK_W)
  ) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (w_state_change),
    .half_period (w_half_period),
    .phase       (w_phase)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= LVL_IDLE;
      r_hold   <= '0;
      r_mute   <= 1'b0;
      r_ack_q  <= 1'b0;
      r_led    <= 1'b0;
      r_buzzer <= 1'b0;
      r_lock   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_hold   <= w_hold_d;
      r_mute   <= w_mute_d;
      r_ack_q  <= ack;
      r_led    <= w_led_d;
      r_buzzer <= w_buzzer_d;
      r_lock   <= w_lock_d;
    end
  end

  assign current_level = r_state;
  assign alarm_led     = r_led;
  assign buzzer        = r_buzzer;
  assign door_lock     = r_lock;

endmodule

// File: tb/tb_security_response_controller.sv
// Directed bench for security_response_controller with small clock/hold parameters.
module tb_security_response_controller;

  logic       clk;
  logic       rst_n;
  logic [1:0] security_level;
  logic       ack;
  logic [1:0] current_level;
  logic       alarm_led;
  logic       buzzer;
  logic       door_lock;

  int checks;
  int errors;

  security_response_controller #(
    .CLOCK_RATE       (100),
    .BLINK_HZ_L1      (1),
    .BLINK_HZ_L2      (4),
    .HOLD_TIME_IN_SEC (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .security_level (security_level),
    .ack            (ack),
    .current_level  (current_level),
    .alarm_led      (alarm_led),
    .buzzer         (buzzer),
    .door_lock      (door_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic led, input logic bz, input logic lk);
    chk({tag, "_led"}, {1'b0, alarm_led}, {1'b0, led});
    chk({tag, "_buz"}, {1'b0, buzzer}, {1'b0, bz});
    chk({tag, "_lock"}, {1'b0, door_lock}, {1'b0, lk});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    security_level = 2'd3;
    ack = 1'b0;

    // Reset with lockdown level pending
    tick(2);
    chk("rst_level", current_level, 2'd0);
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1);
    chk("rel_level", current_level, 2'd3);
    chk_out("rel_pins_lag", 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_out("lock_pins", 1'b1, 1'b1, 1'b1);

    // Drop level without ack: latched
    security_level = 2'd0;
    tick(3);
    chk("lock_latched", current_level, 2'd3);
    ack = 1'b1;
    tick(1);
    chk("ack_exit", current_level, 2'd0);
    ack = 1'b0;
    tick(1);
    chk_out("idle_pins", 1'b0, 1'b0, 1'b0);

    // WATCH blink: high 50 samples, low 50
    security_level = 2'd1;
    tick(1);
    chk("watch_level", current_level, 2'd1);
    tick(1);
    chk_out("watch_first", 1'b1, 1'b0, 1'b0);
    tick(49);
    chk_out("watch_last_hi", 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_out("watch_first_lo", 1'b0, 1'b0, 1'b0);
    tick(49);
    chk_out("watch_last_lo", 1'b0, 1'b0, 1'b0);
    tick(1);
    chk_out("watch_hi_again", 1'b1, 1'b0, 1'b0);

    // WARN blink at half period 12
    security_level = 2'd2;
    tick(1);
    chk("warn_level", current_level, 2'd2);
    tick(1);
    chk_out("warn_first", 1'b1, 1'b1, 1'b0);
    tick(11);
    chk_out("warn_last_hi", 1'b1, 1'b1, 1'b0);
    tick(1);
    chk_out("warn_first_lo", 1'b0, 1'b0, 1'b0);

    // Hold interrupted at 99 cycles, then full 100-cycle hold
    security_level = 2'd1;
    tick(99);
    chk("hold99", current_level, 2'd2);
    security_level = 2'd2;
    tick(1);
    chk("hold_restart", current_level, 2'd2);
    security_level = 2'd1;
    tick(99);
    chk("hold99_again", current_level, 2'd2);
    tick(1);
    chk("hold100", current_level, 2'd1);

    // Mute in WARN: buzzer silenced, LED keeps blinking
    security_level = 2'd2;
    tick(1);
    chk("warn2_level", current_level, 2'd2);
    tick(1);
    chk_out("warn2_first", 1'b1, 1'b1, 1'b0);
    ack = 1'b1;
    tick(1);
    chk_out("mute_lag", 1'b1, 1'b1, 1'b0);
    ack = 1'b0;
    tick(1);
    chk_out("muted_hi", 1'b1, 1'b0, 1'b0);
    tick(10);
    chk_out("muted_lo", 1'b0, 1'b0, 1'b0);
    tick(12);
    chk_out("muted_hi2", 1'b1, 1'b0, 1'b0);
    chk("muted_level", current_level, 2'd2);

    // Escalation and ack in the same cycle
    security_level = 2'd3;
    ack = 1'b1;
    tick(1);
    chk("esc_ack_level", current_level, 2'd3);
    tick(1);
    chk_out("esc_ack_pins", 1'b1, 1'b1, 1'b1);

    // Ack held high: no new rising edge, no exit
    tick(20);
    chk("held_ack_l3", current_level, 2'd3);
    security_level = 2'd1;
    tick(5);
    chk("held_ack_l1", current_level, 2'd3);
    ack = 1'b0;
    tick(1);
    chk("ack_low", current_level, 2'd3);
    ack = 1'b1;
    tick(1);
    chk("new_rise_exit", current_level, 2'd1);
    ack = 1'b0;
    tick(1);
    chk_out("exit_to_watch", 1'b1, 1'b0, 1'b0);

    // Escalate to WARN with simultaneous ack: mute must stay clear
    security_level = 2'd2;
    ack = 1'b1;
    tick(1);
    chk("esc_warn_level", current_level, 2'd2);
    tick(1);
    chk_out("esc_warn_pins", 1'b1, 1'b1, 1'b0);
    tick(1);
    chk_out("esc_warn_unmuted", 1'b1, 1'b1, 1'b0);
    ack = 1'b0;

    // Ack rise with level still 3 is ignored; reset mid-lockdown
    security_level = 2'd3;
    tick(2);
    chk("lock2_level", current_level, 2'd3);
    ack = 1'b1;
    tick(1);
    chk("ack_ignored_l3", current_level, 2'd3);
    chk_out("lock2_pins", 1'b1, 1'b1, 1'b1);
    ack = 1'b0;
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_level", current_level, 2'd0);
    chk_out("mid_rst_pins", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    security_level = 2'd0;
    tick(2);
    chk("post_rst_idle", current_level, 2'd0);
    chk_out("post_rst_pins", 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
